// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one word-aligned request at a time and buffers
// returned instructions in a 2-entry FIFO ahead of the IF/ID latch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] npc_out,
    output logic        valid_out
);

    localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] instr0_q, instr0_d, npc0_q, npc0_d;
    logic [31:0] instr1_q, instr1_d, npc1_q, npc1_d;
    logic        imem_req_q, imem_req_d;
    logic        valid_q, valid_d;

    logic        push;
    logic        pop;
    logic [31:0] seq_addr;

    logic        unused_pc_lsbs;
    assign unused_pc_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        count_d    = count_q;
        instr0_d   = instr0_q;
        npc0_d     = npc0_q;
        instr1_d   = instr1_q;
        npc1_d     = npc1_q;
        push       = 1'b0;
        pop        = valid_q && !stall;
        seq_addr   = req_addr_q + 32'd4;

        case (state_q)
            S_IDLE: begin
                if (!redirect && (count_q < DEPTH)) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                    if (!redirect) begin
                        push       = 1'b1;
                        fetch_pc_d = seq_addr;
                    end
                end else if (redirect) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The stale response is swallowed; only the ack matters here.
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            count_d    = 2'd0;
            instr0_d   = 32'h0;
            npc0_d     = 32'h0;
            instr1_d   = 32'h0;
            npc1_d     = 32'h0;
        end else begin
            // Entry 0 is always the head; unoccupied entries are kept at zero
            // so the outputs read NOP/0 when the buffer is empty.
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        instr0_d = imem_rdata;
                        npc0_d   = seq_addr;
                    end else begin
                        instr1_d = imem_rdata;
                        npc1_d   = seq_addr;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    instr0_d = instr1_q;
                    npc0_d   = npc1_q;
                    instr1_d = 32'h0;
                    npc1_d   = 32'h0;
                    count_d  = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        instr0_d = imem_rdata;
                        npc0_d   = seq_addr;
                    end else begin
                        instr0_d = instr1_q;
                        npc0_d   = npc1_q;
                        instr1_d = imem_rdata;
                        npc1_d   = seq_addr;
                    end
                end
                default: begin
                end
            endcase
        end

        imem_req_d = (state_d != S_IDLE);
        valid_d    = (count_d != 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= 32'h0;
            count_q    <= 2'd0;
            instr0_q   <= 32'h0;
            npc0_q     <= 32'h0;
            instr1_q   <= 32'h0;
            npc1_q     <= 32'h0;
            imem_req_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            instr0_q   <= instr0_d;
            npc0_q     <= npc0_d;
            instr1_q   <= instr1_d;
            npc1_q     <= npc1_d;
            imem_req_q <= imem_req_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = req_addr_q;
    assign instr_out = instr0_q;
    assign npc_out   = npc0_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory responder and
// a queue-based model of the fetch buffer checked on every falling edge.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] npc_out;
    logic        valid_out;

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int mcnt  = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_out  (instr_out),
        .npc_out    (npc_out),
        .valid_out  (valid_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2010_0001;
        return (a ^ 32'h5A5A_0000) + 32'h13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory: acks `lat` cycles after the first cycle a request is visible.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst || !imem_req || imem_ack) begin
                imem_ack = 1'b0;
                mcnt     = 0;
            end else if (mcnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                mcnt++;
            end
        end
    end

    // Reference model: one outstanding request, a discard flag for flushed
    // responses, and a queue for the buffered {instr, npc} pairs.
    logic [63:0] mq[$];
    bit          m_busy;
    bit          m_discard;
    logic [31:0] m_raddr;
    logic [31:0] m_pc;
    int          m_n;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_busy    = 1'b0;
            m_discard = 1'b0;
            m_raddr   = 32'h0;
            m_pc      = 32'h0;
        end else begin
            m_n = mq.size();
            if (redirect) begin
                mq.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
                if (m_busy && imem_ack) begin
                    m_busy    = 1'b0;
                    m_discard = 1'b0;
                end else if (m_busy) begin
                    m_discard = 1'b1;
                end
            end else begin
                if (m_n > 0 && !stall) void'(mq.pop_front());
                if (m_busy && imem_ack) begin
                    if (!m_discard) begin
                        mq.push_back({imem_rdata, m_raddr + 32'd4});
                        m_pc = m_raddr + 32'd4;
                    end
                    m_busy    = 1'b0;
                    m_discard = 1'b0;
                end else if (!m_busy && m_n < 2) begin
                    m_busy  = 1'b1;
                    m_raddr = m_pc;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_valid", {31'h0, valid_out}, {31'h0, (mq.size() > 0)});
            chk("model_instr", instr_out, (mq.size() > 0) ? mq[0][63:32] : 32'h0);
            chk("model_npc", npc_out, (mq.size() > 0) ? mq[0][31:0] : 32'h0);
            chk("model_req", {31'h0, imem_req}, {31'h0, m_busy});
            if (m_busy) chk("model_addr", imem_addr, m_raddr);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [47:0] pat;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        lat         = 1;
        step(3);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, valid_out}, 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_npc", npc_out, 32'h0);
        rst = 1'b0;

        // First fetch after reset release.
        step(1);
        chk("c1_req", {31'h0, imem_req}, 32'h1);
        chk("c1_addr", imem_addr, 32'h0);
        step(2);
        chk("c3_valid", {31'h0, valid_out}, 32'h1);
        chk("c3_instr", instr_out, 32'h2010_0001);
        chk("c3_npc", npc_out, 32'h4);

        // Stall for 10 cycles: buffer fills to two and requests stop.
        stall = 1'b1;
        step(10);
        chk("stall_req", {31'h0, imem_req}, 32'h0);
        chk("stall_valid", {31'h0, valid_out}, 32'h1);
        chk("stall_head_npc", npc_out, 32'h4);
        chk("stall_head_instr", instr_out, 32'h2010_0001);
        stall = 1'b0;
        step(1);
        chk("pop1_npc", npc_out, 32'h8);
        chk("pop1_instr", instr_out, 32'h5A5A_0017);
        chk("pop1_req", {31'h0, imem_req}, 32'h0);
        step(1);
        chk("pop2_valid", {31'h0, valid_out}, 32'h0);
        chk("refetch_req", {31'h0, imem_req}, 32'h1);
        chk("refetch_addr", imem_addr, 32'h8);

        // Redirect while waiting on a slow memory.
        lat         = 3;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        step(1);
        chk("drain_req", {31'h0, imem_req}, 32'h1);
        chk("drain_addr", imem_addr, 32'h8);
        chk("drain_valid", {31'h0, valid_out}, 32'h0);
        redirect = 1'b0;
        step(3);
        chk("drained_req", {31'h0, imem_req}, 32'h0);
        chk("drained_valid", {31'h0, valid_out}, 32'h0);
        step(1);
        chk("redir_req", {31'h0, imem_req}, 32'h1);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_valid", {31'h0, valid_out}, 32'h0);

        // Redirect coinciding with ack and pop.
        lat   = 1;
        stall = 1'b1;
        step(2);
        chk("pre_valid", {31'h0, valid_out}, 32'h1);
        chk("pre_npc", npc_out, 32'h104);
        step(1);
        chk("pre_addr", imem_addr, 32'h104);
        step(1);
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step(1);
        chk("flush_valid", {31'h0, valid_out}, 32'h0);
        chk("flush_instr", instr_out, 32'h0);
        chk("flush_npc", npc_out, 32'h0);
        chk("flush_req", {31'h0, imem_req}, 32'h0);
        redirect = 1'b0;
        step(1);
        chk("flush_next_addr", imem_addr, 32'h200);

        // Redirect to the top word: npc wraps to zero.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step(1);
        redirect = 1'b0;
        step(2);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        step(2);
        chk("wrap_valid", {31'h0, valid_out}, 32'h1);
        chk("wrap_npc", npc_out, 32'h0);
        chk("wrap_instr", instr_out, 32'hA5A6_000F);
        stall = 1'b1;
        step(1);
        chk("wrap_next_req", {31'h0, imem_req}, 32'h1);
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Asynchronous reset in the middle of a WAIT cycle.
        #1;
        rst = 1'b1;
        #1;
        chk("arst_req", {31'h0, imem_req}, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_valid", {31'h0, valid_out}, 32'h0);
        chk("arst_instr", instr_out, 32'h0);
        chk("arst_npc", npc_out, 32'h0);
        stall = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        chk("restart_req", {31'h0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h0);

        // Mixed stall pattern with two close redirects, checked by the model.
        lat = 2;
        pat = 48'hF0C3_3A5E_0F81;
        for (int i = 0; i < 48; i++) begin
            stall       = pat[i];
            redirect    = (i == 20) || (i == 23);
            redirect_pc = (i == 20) ? 32'h0000_0041 : 32'h0000_0083;
            step(1);
        end
        stall    = 1'b0;
        redirect = 1'b0;
        step(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: address of the first fetch after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: depth of the instruction buffer; fixed at 2 for this revision.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port imem_req  output  1: instruction-memory request, held high until acknowledged.
REQ-006 SHALL have port imem_addr  output  32: word-aligned fetch address, stable while imem_req is high.
REQ-007 SHALL have port imem_ack  input  1: memory response valid; sampled only while imem_req is high.
REQ-008 SHALL have port imem_rdata  input  32: instruction word, valid when imem_ack is high.
REQ-009 SHALL have port stall  input  1: downstream IF/ID latch cannot accept this cycle.
REQ-010 SHALL have port redirect  input  1: taken branch or jump; flush and refetch.
REQ-011 SHALL have port redirect_pc  input  32: target address for redirect.
REQ-012 SHALL have port instr_out  output  32: instruction presented to the IF/ID latch.
REQ-013 SHALL have port npc_out  output  32: address of instr_out plus 4.
REQ-014 SHALL have port valid_out  output  1: instr_out and npc_out are valid.

Function
REQ-015 SHALL hold fetch_pc, a 3-state FSM (IDLE, WAIT, DRAIN) and a 2-entry FIFO of {instr, npc}.
REQ-016 SHALL drive imem_req high exactly when the state is WAIT or DRAIN, and SHALL drive imem_addr from a registered request address.
REQ-017 In IDLE, with FIFO count < 2 and redirect low: latch fetch_pc into the request address and go to WAIT; otherwise stay in IDLE.
REQ-018 In WAIT, when imem_ack is high and redirect is low: push {imem_rdata, req_addr+4}, set fetch_pc to req_addr+4, and go to IDLE. Otherwise stay in WAIT.
REQ-019 Allow at most one outstanding request; peak throughput is 1 instruction per 2 cycles.
REQ-020 Drive valid_out from FIFO non-empty, and drive instr_out and npc_out from the FIFO head (registered, no combinational path from imem_rdata).
REQ-021 When the FIFO is empty, drive instr_out = 32'h0000_0000 (NOP) and npc_out = 32'h0000_0000.
REQ-022 Pop the head on any cycle with valid_out high and stall low; a push and a pop in the same cycle leave the count unchanged.
REQ-023 Never overflow the FIFO; issue is gated by count < 2, so push only occurs when count <= 1 or when a pop occurs in the same cycle.
REQ-024 On redirect high in any state:
  - empty the FIFO (valid_out low the next cycle);
  - set fetch_pc to {redirect_pc[31:2], 2'b00};
  - redirect takes priority over push and pop.
REQ-025 Redirect state transitions:
  - in WAIT with imem_ack low: go to DRAIN;
  - in WAIT with imem_ack high: discard the data and go to IDLE;
  - in IDLE: stay in IDLE with no issue that cycle.
REQ-026 In DRAIN: keep imem_req and imem_addr until imem_ack, discard the data, then go to IDLE; a further redirect during DRAIN updates fetch_pc and the state stays in DRAIN.
REQ-027 Compute the address increment modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000); this is not an error.
REQ-028 Make stall affect only the pop; fetching continues until the FIFO is full.

Reset
REQ-029 While rst is high, asynchronously force:
  - state to IDLE, fetch_pc to RESET_PC, FIFO count to 0;
  - imem_req to 0, valid_out to 0, instr_out to 0, npc_out to 0, imem_addr to 0.
REQ-030 On reset asserted mid-transaction, drop the outstanding request with no DRAIN; after release, the first request goes to RESET_PC in the first WAIT cycle.

Verification
REQ-031 The bench SHALL cover: reset release with 1-cycle-ack memory returning 0x2010_0001 at address 0 -> imem_addr=0x0 in cycle 1, valid_out=1 with instr_out=0x2010_0001 and npc_out=0x4 in cycle 3.
REQ-032 The bench SHALL cover: stall held high for 10 cycles -> exactly 2 instructions buffered, imem_req low thereafter, and no instruction lost or duplicated after stall drops.
REQ-033 The bench SHALL cover: redirect to 0x0000_0103 while WAIT with a 3-cycle ack latency -> DRAIN, the returned data is discarded, and the next imem_addr = 0x0000_0100.
REQ-034 The bench SHALL cover: redirect coincident with imem_ack and a pop -> FIFO empty next cycle, valid_out=0, and no push.
REQ-035 The bench SHALL cover: redirect to 0xFFFF_FFFC -> npc_out=0x0000_0000, and the next imem_addr = 0x0000_0000.
REQ-036 The bench SHALL cover: rst pulsed mid-WAIT -> all outputs 0 immediately (asynchronously), with the restart at RESET_PC.
